// File: rtl/t5_wbarb.sv
// Two-to-one Wishbone arbiter: fetch and data buses share one registered master port,
// with bounded data-priority fairness and a per-transfer ack timeout.
module t5_wbarb #(
    parameter int XLEN = 32,
    parameter int FAIR = 4,
    parameter int TMO  = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            iwb_stb,
    input  logic            iwb_wre,
    input  logic [3:0]      iwb_sel,
    input  logic [29:0]     iwb_adr,
    output logic            iwb_ack,
    output logic            iwb_err,
    output logic [XLEN-1:0] iwb_dat,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    input  logic [3:0]      dwb_sel,
    input  logic [29:0]     dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    output logic            dwb_ack,
    output logic            dwb_err,
    output logic [XLEN-1:0] dwb_dti,
    output logic            mwb_stb,
    output logic            mwb_wre,
    output logic [3:0]      mwb_sel,
    output logic [29:0]     mwb_adr,
    output logic [XLEN-1:0] mwb_dto,
    input  logic [XLEN-1:0] mwb_dti,
    input  logic            mwb_ack
);

    localparam int DW = $clog2(FAIR + 1);
    localparam int TW = $clog2(TMO);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IBUS = 2'd1;
    localparam logic [1:0] S_DBUS = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            stb_q, stb_d;
    logic            wre_q, wre_d;
    logic [3:0]      sel_q, sel_d;
    logic [29:0]     adr_q, adr_d;
    logic [XLEN-1:0] dto_q, dto_d;

    logic busy_s, timeout_s, done_s, grant_d_s;

    assign busy_s    = (state_q == S_IBUS) || (state_q == S_DBUS);
    // Ack takes precedence over a timeout landing in the same cycle.
    assign timeout_s = busy_s && (tcnt_q == TW'(TMO - 1)) && !mwb_ack;
    assign done_s    = busy_s && (mwb_ack || timeout_s);
    assign grant_d_s = dwb_stb && (!iwb_stb || (dcnt_q < DW'(FAIR)));

    // Next-state, grant capture and counter updates.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        stb_d   = stb_q;
        wre_d   = wre_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dto_d   = dto_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d_s) begin
                    state_d = S_DBUS;
                    stb_d   = 1'b1;
                    wre_d   = dwb_wre;
                    sel_d   = dwb_sel;
                    adr_d   = dwb_adr;
                    dto_d   = dwb_dto;
                    tcnt_d  = '0;
                    if (!iwb_stb) begin
                        dcnt_d = '0;
                    end else if (dcnt_q == DW'(FAIR)) begin
                        dcnt_d = dcnt_q;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end else if (iwb_stb) begin
                    state_d = S_IBUS;
                    stb_d   = 1'b1;
                    wre_d   = iwb_wre;
                    sel_d   = iwb_sel;
                    adr_d   = iwb_adr;
                    dto_d   = '0;
                    tcnt_d  = '0;
                    dcnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IBUS, S_DBUS: begin
                if (done_s) begin
                    state_d = S_IDLE;
                    stb_d   = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and master-port registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            stb_q   <= 1'b0;
            wre_q   <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 30'h0;
            dto_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            stb_q   <= stb_d;
            wre_q   <= wre_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dto_q   <= dto_d;
        end
    end

    assign mwb_stb = stb_q;
    assign mwb_wre = wre_q;
    assign mwb_sel = sel_q;
    assign mwb_adr = adr_q;
    assign mwb_dto = dto_q;

    // Responses steered to the granted side only; the other side reads zero.
    assign iwb_ack = (state_q == S_IBUS) && mwb_ack;
    assign iwb_err = (state_q == S_IBUS) && timeout_s;
    assign iwb_dat = ((state_q == S_IBUS) && mwb_ack) ? mwb_dti : '0;
    assign dwb_ack = (state_q == S_DBUS) && mwb_ack;
    assign dwb_err = (state_q == S_DBUS) && timeout_s;
    assign dwb_dti = ((state_q == S_DBUS) && mwb_ack) ? mwb_dti : '0;

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed scoreboard bench for t5_wbarb: expected grants are queued as requests are
// driven and checked when the master port presents them.
module tb_t5_wbarb;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        iwb_stb = 1'b0, iwb_wre = 1'b0;
    logic [3:0]  iwb_sel = 4'h0;
    logic [29:0] iwb_adr = 30'h0;
    logic        iwb_ack, iwb_err;
    logic [31:0] iwb_dat;
    logic        dwb_stb = 1'b0, dwb_wre = 1'b0;
    logic [3:0]  dwb_sel = 4'h0;
    logic [29:0] dwb_adr = 30'h0;
    logic [31:0] dwb_dto = 32'h0;
    logic        dwb_ack, dwb_err;
    logic [31:0] dwb_dti;
    logic        mwb_stb, mwb_wre;
    logic [3:0]  mwb_sel;
    logic [29:0] mwb_adr;
    logic [31:0] mwb_dto;
    logic [31:0] mwb_dti = 32'h0;
    logic        mwb_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          side;   // 0 = fetch, 1 = data
        logic [29:0] adr;
        logic        wre;
        logic [3:0]  sel;
        logic [31:0] dto;
        logic [31:0] rdat;
        bit          drop;   // release both stb lines on this ack
    } exp_t;

    exp_t sb[$];

    t5_wbarb #(.XLEN(32), .FAIR(4), .TMO(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel), .iwb_adr(iwb_adr),
        .iwb_ack(iwb_ack), .iwb_err(iwb_err), .iwb_dat(iwb_dat),
        .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel), .dwb_adr(dwb_adr),
        .dwb_dto(dwb_dto), .dwb_ack(dwb_ack), .dwb_err(dwb_err), .dwb_dti(dwb_dti),
        .mwb_stb(mwb_stb), .mwb_wre(mwb_wre), .mwb_sel(mwb_sel), .mwb_adr(mwb_adr),
        .mwb_dto(mwb_dto), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit side, input logic [29:0] adr, input logic wre,
                        input logic [3:0] sel, input logic [31:0] dto,
                        input logic [31:0] rdat, input bit drop);
        exp_t e;
        e.side = side; e.adr = adr; e.wre = wre; e.sel = sel;
        e.dto = dto; e.rdat = rdat; e.drop = drop;
        sb.push_back(e);
    endtask

    // Called in the IDLE cycle where a request is visible; serves the next queued grant.
    task automatic serve(input int delay);
        exp_t e;
        tick();
        chk("grant_latency", {31'h0, mwb_stb}, 32'h1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'h1, 32'h0);
            return;
        end
        e = sb.pop_front();
        chk("mwb_adr", {2'b00, mwb_adr}, {2'b00, e.adr});
        chk("mwb_wre", {31'h0, mwb_wre}, {31'h0, e.wre});
        chk("mwb_sel", {28'h0, mwb_sel}, {28'h0, e.sel});
        chk("mwb_dto", mwb_dto, e.dto);
        for (int k = 0; k < delay; k++) begin
            chk("early_ack", {30'h0, iwb_ack, dwb_ack}, 32'h0);
            tick();
            chk("stb_held", {31'h0, mwb_stb}, 32'h1);
        end
        mwb_dti = e.rdat;
        mwb_ack = 1'b1;
        #1;
        chk("iwb_ack", {31'h0, iwb_ack}, {31'h0, !e.side});
        chk("dwb_ack", {31'h0, dwb_ack}, {31'h0, e.side});
        chk("err_on_ack", {30'h0, iwb_err, dwb_err}, 32'h0);
        chk("iwb_dat", iwb_dat, e.side ? 32'h0 : e.rdat);
        chk("dwb_dti", dwb_dti, e.side ? e.rdat : 32'h0);
        if (e.drop) begin
            iwb_stb = 1'b0;
            dwb_stb = 1'b0;
        end
        tick();
        mwb_ack = 1'b0;
        mwb_dti = 32'h0;
        #1;
        chk("stb_cleared", {31'h0, mwb_stb}, 32'h0);
        chk("ack_pulse", {30'h0, iwb_ack, dwb_ack}, 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_mwb", {mwb_stb, mwb_wre, mwb_sel, 26'h0}, 32'h0);
        chk("rst_adr", {2'b00, mwb_adr}, 32'h0);
        chk("rst_dto", mwb_dto, 32'h0);
        chk("rst_resp", {28'h0, iwb_ack, iwb_err, dwb_ack, dwb_err}, 32'h0);
        tick();
        sys_rst = 1'b0;
        tick();

        // Single fetch
        iwb_stb = 1'b1; iwb_adr = 30'h100; iwb_sel = 4'hF; iwb_wre = 1'b0;
        push(1'b0, 30'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1);
        serve(0);

        // Data write
        dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_sel = 4'h3; dwb_adr = 30'h0AB; dwb_dto = 32'h12345678;
        push(1'b1, 30'h0AB, 1'b1, 4'h3, 32'h12345678, 32'h0000CAFE, 1'b1);
        serve(2);

        // Simultaneous requests: D,D,D,D,I repeated with FAIR=4
        iwb_stb = 1'b1; iwb_adr = 30'h200; iwb_sel = 4'hF;
        dwb_stb = 1'b1; dwb_wre = 1'b0; dwb_sel = 4'hF; dwb_adr = 30'h300; dwb_dto = 32'hA5A5A5A5;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++)
                push(1'b1, 30'h300, 1'b0, 4'hF, 32'hA5A5A5A5, 32'h1000 + 32'(r * 8 + d), 1'b0);
            push(1'b0, 30'h200, 1'b0, 4'hF, 32'h0, 32'h2000 + 32'(r), r == 1);
        end
        for (int n = 0; n < 10; n++) serve(0);

        // Timeout: no ack, err on the 16th busy cycle
        dwb_stb = 1'b1; dwb_wre = 1'b0; dwb_sel = 4'hF; dwb_adr = 30'h044;
        tick();
        chk("tmo_grant", {31'h0, mwb_stb}, 32'h1);
        for (int c = 1; c < 16; c++) begin
            chk("tmo_early_err", {30'h0, dwb_err, iwb_err}, 32'h0);
            tick();
        end
        chk("tmo_err", {31'h0, dwb_err}, 32'h1);
        chk("tmo_no_ack", {30'h0, dwb_ack, iwb_err}, 32'h0);
        dwb_stb = 1'b0;
        tick();
        chk("tmo_stb_low", {31'h0, mwb_stb}, 32'h0);
        chk("tmo_err_pulse", {31'h0, dwb_err}, 32'h0);

        // Ack on the 16th busy cycle beats the timeout
        dwb_stb = 1'b1; dwb_adr = 30'h048;
        push(1'b1, 30'h048, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b1);
        dwb_dto = 32'h0;
        serve(15);

        // Stray ack in IDLE
        mwb_ack = 1'b1; mwb_dti = 32'hFFFFFFFF;
        #1;
        chk("stray_ack", {30'h0, iwb_ack, dwb_ack}, 32'h0);
        chk("stray_dat", iwb_dat | dwb_dti, 32'h0);
        tick();
        chk("stray_stb", {31'h0, mwb_stb}, 32'h0);
        mwb_ack = 1'b0; mwb_dti = 32'h0;

        // Reset mid-DBUS
        dwb_stb = 1'b1; dwb_adr = 30'h3FF; dwb_wre = 1'b1; dwb_dto = 32'h55AA55AA;
        tick();
        chk("abort_grant", {31'h0, mwb_stb}, 32'h1);
        sys_rst = 1'b1;
        mwb_ack = 1'b1;
        #1;
        chk("abort_stb", {31'h0, mwb_stb}, 32'h0);
        chk("abort_adr", {2'b00, mwb_adr}, 32'h0);
        chk("abort_dto", mwb_dto, 32'h0);
        chk("abort_ack", {30'h0, dwb_ack, dwb_err}, 32'h0);
        dwb_stb = 1'b0; dwb_wre = 1'b0; mwb_ack = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        iwb_stb = 1'b1; iwb_adr = 30'h3C0;
        push(1'b0, 30'h3C0, 1'b0, 4'hF, 32'h0, 32'h13579BDF, 1'b1);
        serve(1);

        chk("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
